edu_sched: RTL and testbench

Round-robin scheduler that shares one Hamming(7,4) error-decode unit (EDU) among `N_REQ` requesters in the network-on-chip datapath. It accepts 7-bit codewords from requesters over valid/ready handshakes and issues them one at a time to the shared decoder. It returns each corrected word tagged with the originating requester ID and keeps a saturating count of corrected words. At most one transaction is in flight at any time.

---
 rtl/edu_sched.sv | 87 ++++++++
 tb/tb_edu_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/edu_sched.sv
// edu_sched: round-robin scheduler sharing one Hamming(7,4) decoder among N_REQ requesters
module edu_sched #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*7-1:0] req_data,
  output logic [N_REQ-1:0]   req_ready,
  output logic               dec_valid,
  output logic [6:0]         dec_data,
  input  logic               dec_ready,
  input  logic               dec_rsp_valid,
  input  logic [6:0]         dec_rsp_data,
  input  logic [2:0]         dec_rsp_syn,
  output logic               rsp_valid,
  output logic [6:0]         rsp_data,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_corr,
  input  logic               rsp_ready,
  output logic [CNT_W-1:0]   corr_cnt,
  output logic               proto_err
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RETURN} state_t;
  state_t state;
  logic [ID_W-1:0] rr_ptr, gnt, idx, cur_id;
  logic hit;
  logic [N_REQ-1:0][6:0] lane;
  assign lane = req_data;
  always_comb begin
    gnt = rr_ptr;
    idx = '0;
    hit = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!hit && req_valid[idx]) begin
        hit = 1'b1;
        gnt = idx;
      end
    end
  end
  assign req_ready = (rst_n && state == IDLE && hit) ? {{(N_REQ-1){1'b0}}, 1'b1} << gnt : '0;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      cur_id    <= '0;
      dec_valid <= 1'b0;
      dec_data  <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rsp_corr  <= 1'b0;
      corr_cnt  <= '0;
      proto_err <= 1'b0;
    end else begin
      if (dec_rsp_valid && state != WAIT) proto_err <= 1'b1;
      case (state)
        IDLE: if (hit) begin
          dec_data  <= lane[gnt];
          cur_id    <= gnt;
          rr_ptr    <= (gnt == ID_W'(N_REQ-1)) ? '0 : gnt + 1'b1;
          dec_valid <= 1'b1;
          state     <= ISSUE;
        end
        ISSUE: if (dec_ready) begin
          dec_valid <= 1'b0;
          state     <= WAIT;
        end
        WAIT: if (dec_rsp_valid) begin
          rsp_data  <= dec_rsp_data;
          rsp_id    <= cur_id;
          rsp_corr  <= |dec_rsp_syn;
          if (|dec_rsp_syn && !(&corr_cnt)) corr_cnt <= corr_cnt + 1'b1;
          rsp_valid <= 1'b1;
          state     <= RETURN;
        end
        RETURN: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_edu_sched.sv
// tb_edu_sched: randomized self-checking bench for edu_sched against a queue-free arbitration model
module tb_edu_sched;
  localparam int N = 4, IW = 2, CW = 4, CMAX = (1 << CW) - 1;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N-1:0][6:0] lanes = '0;
  logic dec_valid, dec_ready = 1'b0, dec_rsp_valid = 1'b0;
  logic [6:0] dec_data, dec_rsp_data = '0, rsp_data;
  logic [2:0] dec_rsp_syn = '0;
  logic rsp_valid, rsp_corr, rsp_ready = 1'b0, proto_err;
  logic [IW-1:0] rsp_id;
  logic [CW-1:0] corr_cnt;
  always #5 clk = ~clk;
  edu_sched #(.N_REQ(N), .ID_W(IW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(lanes), .req_ready(req_ready),
    .dec_valid(dec_valid), .dec_data(dec_data), .dec_ready(dec_ready),
    .dec_rsp_valid(dec_rsp_valid), .dec_rsp_data(dec_rsp_data), .dec_rsp_syn(dec_rsp_syn),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_corr(rsp_corr),
    .rsp_ready(rsp_ready), .corr_cnt(corr_cnt), .proto_err(proto_err));
  int n_cmp = 0, n_bad = 0;
  int m_ptr = 0, m_cnt = 0;
  logic [N-1:0] o_gnt;
  logic [6:0] o_dec, o_rdata;
  logic [IW-1:0] o_rid;
  logic o_rcorr, o_dv, o_rv_ret, o_wait_bad, o_stall_bad;
  function automatic int pick(input logic [N-1:0] v);
    for (int k = 0; k < N; k++) if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return 0;
  endfunction
  task automatic randomize_lanes();
    for (int i = 0; i < N; i++) lanes[i] = 7'($urandom);
  endtask
  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_ptr = 0; m_cnt = 0;
  endtask
  // One full transaction; the bench plays requester, decoder and consumer with the given stall lengths.
  task automatic run_txn(input logic [N-1:0] v, input logic [6:0] rd, input logic [2:0] syn,
                         input int dd, input int dw, input int dr);
    @(negedge clk);
    req_valid = v;
    #1 o_gnt = req_ready;
    @(posedge clk);
    o_stall_bad = 1'b0; o_wait_bad = 1'b0;
    @(negedge clk);
    o_dv = dec_valid; o_dec = dec_data;
    for (int k = 0; k <= dd; k++) begin
      if (k > 0) @(negedge clk);
      if (dec_valid !== 1'b1 || dec_data !== o_dec || req_ready !== '0) o_stall_bad = 1'b1;
      dec_ready = (k == dd);
      @(posedge clk);
    end
    for (int k = 0; k <= dw; k++) begin
      @(negedge clk);
      dec_ready = 1'b0;
      if (rsp_valid !== 1'b0 || dec_valid !== 1'b0 || req_ready !== '0) o_wait_bad = 1'b1;
      dec_rsp_valid = (k == dw); dec_rsp_data = rd; dec_rsp_syn = syn;
      @(posedge clk);
    end
    @(negedge clk);
    dec_rsp_valid = 1'b0;
    o_rv_ret = rsp_valid; o_rdata = rsp_data; o_rid = rsp_id; o_rcorr = rsp_corr;
    for (int k = 0; k <= dr; k++) begin
      if (k > 0) @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== o_rdata || rsp_id !== o_rid || rsp_corr !== o_rcorr || req_ready !== '0) o_stall_bad = 1'b1;
      rsp_ready = (k == dr);
      @(posedge clk);
    end
    @(negedge clk);
    rsp_ready = 1'b0; req_valid = '0;
  endtask
  task automatic test_reset();
    #1 rst_n = 1'b0;
    #1 req_valid = '1;
    #1;
    n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_cmp++; if (dec_valid !== 1'b0 || dec_data !== '0) begin n_bad++; $display("FAIL reset_dec: got %b/%h want 0/0", dec_valid, dec_data); end
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0 || rsp_corr !== 1'b0) begin n_bad++; $display("FAIL reset_rsp: got %b/%h/%0d/%b want all 0", rsp_valid, rsp_data, rsp_id, rsp_corr); end
    n_cmp++; if (corr_cnt !== '0 || proto_err !== 1'b0) begin n_bad++; $display("FAIL reset_cnt_err: got %0d/%b want 0/0", corr_cnt, proto_err); end
    repeat (2) @(negedge clk);
    req_valid = '0; rst_n = 1'b1;
    m_ptr = 0; m_cnt = 0;
  endtask
  task automatic test_latency();
    randomize_lanes();
    lanes[2] = 7'b0000000;
    run_txn(4'b0100, 7'b0000000, 3'b000, 0, 0, 0);
    m_ptr = 3;
    n_cmp++; if (o_gnt !== 4'b0100) begin n_bad++; $display("FAIL lat_grant: got %b want 0100", o_gnt); end
    n_cmp++; if (o_dv !== 1'b1 || o_dec !== 7'b0) begin n_bad++; $display("FAIL lat_issue: got %b/%h want 1/00", o_dv, o_dec); end
    n_cmp++; if (o_wait_bad !== 1'b0) begin n_bad++; $display("FAIL lat_early_rsp: got %b want 0", o_wait_bad); end
    n_cmp++; if (o_rv_ret !== 1'b1) begin n_bad++; $display("FAIL lat_rsp_valid_c3: got %b want 1", o_rv_ret); end
    n_cmp++; if (o_rid !== 2'd2 || o_rcorr !== 1'b0) begin n_bad++; $display("FAIL lat_rsp: got id %0d corr %b want 2/0", o_rid, o_rcorr); end
    n_cmp++; if (corr_cnt !== 0) begin n_bad++; $display("FAIL lat_cnt: got %0d want 0", corr_cnt); end
  endtask
  task automatic test_round_robin();
    logic [6:0] rd, el;
    int g;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      randomize_lanes();
      el = lanes[k % N];
      rd = 7'($urandom);
      run_txn(4'b1111, rd, 3'b000, 0, 0, 0);
      m_ptr = (k + 1) % N;
      n_cmp++; if (o_rid !== IW'(k % N) || o_gnt !== N'(1) << (k % N)) begin n_bad++; $display("FAIL rr_seq[%0d]: got id %0d grant %b want %0d", k, o_rid, o_gnt, k % N); end
      n_cmp++; if (o_dec !== el || o_rdata !== rd) begin n_bad++; $display("FAIL rr_data[%0d]: got %h/%h want %h/%h", k, o_dec, o_rdata, el, rd); end
    end
    run_txn(4'b1111, 7'h11, 3'b000, 0, 0, 0);
    run_txn(4'b1111, 7'h22, 3'b000, 0, 0, 0);
    n_cmp++; if (o_rid !== 2'd1) begin n_bad++; $display("FAIL rr_pre_single: got %0d want 1", o_rid); end
    m_ptr = 2;
    g = pick(4'b0010);
    run_txn(4'b0010, 7'h33, 3'b000, 0, 0, 0);
    m_ptr = (g + 1) % N;
    n_cmp++; if (o_rid !== IW'(g) || o_gnt !== 4'b0010) begin n_bad++; $display("FAIL rr_single: got id %0d grant %b want %0d/0010", o_rid, o_gnt, g); end
  endtask
  task automatic test_corrected();
    logic [N-1:0] v;
    logic [2:0] syn;
    int g;
    v = N'($urandom_range(1, 15));
    g = pick(v);
    run_txn(v, 7'b1010101, 3'b101, 0, 0, 0);
    m_ptr = (g + 1) % N;
    m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
    n_cmp++; if (o_rdata !== 7'b1010101 || o_rcorr !== 1'b1) begin n_bad++; $display("FAIL corr_word: got %b/%b want 1010101/1", o_rdata, o_rcorr); end
    n_cmp++; if (corr_cnt !== CW'(m_cnt)) begin n_bad++; $display("FAIL corr_inc: got %0d want %0d", corr_cnt, m_cnt); end
    for (int k = 0; k < 17; k++) begin
      v = N'($urandom_range(1, 15));
      syn = 3'($urandom_range(1, 7));
      g = pick(v);
      run_txn(v, 7'($urandom), syn, 0, 0, 0);
      m_ptr = (g + 1) % N;
      m_cnt = (m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
      n_cmp++; if (corr_cnt !== CW'(m_cnt) || o_rcorr !== 1'b1) begin n_bad++; $display("FAIL corr_run[%0d]: got %0d/%b want %0d/1", k, corr_cnt, o_rcorr, m_cnt); end
    end
    n_cmp++; if (corr_cnt !== CW'(CMAX)) begin n_bad++; $display("FAIL corr_sat: got %0d want %0d", corr_cnt, CMAX); end
  endtask
  task automatic test_backpressure();
    logic [6:0] rd, el;
    int g;
    randomize_lanes();
    g = pick(4'b1011);
    el = lanes[g];
    rd = 7'($urandom);
    run_txn(4'b1011, rd, 3'b000, 5, 0, 5);
    m_ptr = (g + 1) % N;
    n_cmp++; if (o_stall_bad !== 1'b0) begin n_bad++; $display("FAIL bp_stable: got %b want 0", o_stall_bad); end
    n_cmp++; if (o_dv !== 1'b1 || o_dec !== el) begin n_bad++; $display("FAIL bp_dec: got %b/%h want 1/%h", o_dv, o_dec, el); end
    n_cmp++; if (o_rv_ret !== 1'b1 || o_rid !== IW'(g) || o_rdata !== rd) begin n_bad++; $display("FAIL bp_rsp: got %b/%0d/%h want 1/%0d/%h", o_rv_ret, o_rid, o_rdata, g, rd); end
  endtask
  task automatic test_random();
    logic [N-1:0] v;
    logic [6:0] rd, el;
    logic [2:0] syn;
    int g;
    do_reset();
    for (int k = 0; k < 40; k++) begin
      randomize_lanes();
      v = N'($urandom_range(1, 15));
      rd = 7'($urandom);
      syn = ($urandom_range(0, 1) == 1) ? 3'($urandom) : 3'b000;
      g = pick(v);
      el = lanes[g];
      run_txn(v, rd, syn, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
      m_ptr = (g + 1) % N;
      if (syn != 0 && m_cnt < CMAX) m_cnt++;
      n_cmp++; if (o_gnt !== N'(1) << g || o_dec !== el) begin n_bad++; $display("FAIL rnd_grant[%0d]: got %b/%h want lane %0d/%h", k, o_gnt, o_dec, g, el); end
      n_cmp++; if (o_rid !== IW'(g) || o_rdata !== rd || o_rcorr !== (syn != 0)) begin n_bad++; $display("FAIL rnd_rsp[%0d]: got %0d/%h/%b want %0d/%h/%b", k, o_rid, o_rdata, o_rcorr, g, rd, syn != 0); end
      n_cmp++; if (corr_cnt !== CW'(m_cnt) || proto_err !== 1'b0) begin n_bad++; $display("FAIL rnd_cnt[%0d]: got %0d/%b want %0d/0", k, corr_cnt, proto_err, m_cnt); end
      n_cmp++; if (o_stall_bad !== 1'b0 || o_wait_bad !== 1'b0 || o_rv_ret !== 1'b1) begin n_bad++; $display("FAIL rnd_handshake[%0d]: got %b/%b/%b want 0/0/1", k, o_stall_bad, o_wait_bad, o_rv_ret); end
    end
  endtask
  task automatic test_proto_err();
    @(negedge clk);
    dec_rsp_valid = 1'b1; dec_rsp_syn = 3'b111;
    @(negedge clk);
    dec_rsp_valid = 1'b0;
    n_cmp++; if (proto_err !== 1'b1 || corr_cnt !== CW'(m_cnt)) begin n_bad++; $display("FAIL perr_set: got %b/%0d want 1/%0d", proto_err, corr_cnt, m_cnt); end
    repeat (3) @(negedge clk);
    run_txn(4'b0001, 7'h5a, 3'b000, 0, 0, 0);
    m_ptr = 1;
    n_cmp++; if (proto_err !== 1'b1 || rsp_valid !== 1'b0) begin n_bad++; $display("FAIL perr_sticky: got %b/%b want 1/0", proto_err, rsp_valid); end
  endtask
  task automatic test_reset_mid();
    logic seen;
    @(negedge clk);
    req_valid = 4'b0001;
    @(negedge clk);
    dec_ready = 1'b1;
    @(negedge clk);
    dec_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (dec_valid !== 1'b0 || dec_data !== '0 || req_ready !== '0) begin n_bad++; $display("FAIL rmid_dec: got %b/%h/%b want 0", dec_valid, dec_data, req_ready); end
    n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_id !== '0 || rsp_corr !== 1'b0 || corr_cnt !== '0 || proto_err !== 1'b0) begin n_bad++; $display("FAIL rmid_rsp: got %b/%h/%0d/%b/%0d/%b want 0", rsp_valid, rsp_data, rsp_id, rsp_corr, corr_cnt, proto_err); end
    @(negedge clk);
    rst_n = 1'b1; req_valid = '0;
    dec_rsp_valid = 1'b1; dec_rsp_data = 7'h7f; dec_rsp_syn = 3'b001;
    @(negedge clk);
    dec_rsp_valid = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      if (rsp_valid !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rmid_no_rsp: got %b want 0", seen); end
    n_cmp++; if (proto_err !== 1'b1 || corr_cnt !== '0) begin n_bad++; $display("FAIL rmid_late: got %b/%0d want 1/0", proto_err, corr_cnt); end
  endtask
  initial begin
    test_reset();
    test_latency();
    test_round_robin();
    test_corrected();
    test_backpressure();
    test_random();
    test_proto_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
